ser_deframer: RTL and testbench



---
 rtl/ser_deframer_pkg.sv | 34 +++
 rtl/ser_deframer_if.sv | 33 +++
 rtl/deframer_slot_counter.sv | 59 +++++
 rtl/ser_deframer.sv | 179 +++++++++++++++++
 tb/tb_ser_deframer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ser_deframer_pkg.sv
// ============================================================================
// Module : ser_deframer_pkg
// Brief  : Shared types and constants for the serial deframer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_deframer_pkg;

  // Hunt for the sync word, confirm frame spacing, then stay locked
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } deframer_state_t;

  localparam int         WORD_W            = 8;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // Slot lengths in bits; sync slots never carry a parity bit
  localparam int SYNC_SLOT_LEN       = 8;
  localparam int DATA_SLOT_LEN_NOPAR = 8;
  localparam int DATA_SLOT_LEN_PAR   = 9;
  localparam int BIT_CNT_W_NOPAR     = 3;
  localparam int BIT_CNT_W_PAR       = 4;

  // Saturating increment for the 4-bit good/miss counters
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_deframer_if.sv
// ============================================================================
// Module : ser_deframer_if
// Brief  : Serial input and deframed output bundle of the deframer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ser_deframer_if;
  import ser_deframer_pkg::*;

  logic              ser_in;
  logic              ser_valid;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              locked;
  logic              sync_err;
  logic              parity_err;

  // Source of the bit stream / consumer of the words
  modport master (
    output ser_in, ser_valid,
    input  dout, dout_valid, locked, sync_err, parity_err
  );

  // The deframer itself
  modport slave (
    input  ser_in, ser_valid,
    output dout, dout_valid, locked, sync_err, parity_err
  );

endinterface

`default_nettype wire

// File: rtl/deframer_slot_counter.sv
// ============================================================================
// Module : deframer_slot_counter
// Brief  : Bit-in-slot and word-in-frame counters. Word index FRAME_LEN is
//          the sync slot; every other index is a data slot.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deframer_slot_counter
  import ser_deframer_pkg::*;
#(
  parameter int FRAME_LEN     = 4,
  parameter int DATA_SLOT_LEN = 8,
  parameter int BIT_W         = 3
) (
  input  wire logic clk,
  input  wire logic clr_i,        // synchronous clear (reset, hunt match)
  input  wire logic adv_i,        // accepted bit while aligned
  output logic      slot_done_o,  // this accepted bit completes a slot
  output logic      sync_slot_o   // current slot is the sync slot
);

  localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(SYNC_SLOT_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_SLOT_LEN - 1);
  localparam logic [7:0]       SYNC_IDX  = 8'(FRAME_LEN);

  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             last_bit;

  // Slot decode and next counter values
  always_comb begin
    sync_slot_o = (word_cnt_q == SYNC_IDX);
    last_bit    = sync_slot_o ? (bit_cnt_q == SYNC_LAST) : (bit_cnt_q == DATA_LAST);
    slot_done_o = adv_i & last_bit;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    if (clr_i) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (adv_i) begin
      if (last_bit) begin
        bit_cnt_d  = '0;
        word_cnt_d = sync_slot_o ? 8'd0 : word_cnt_q + 8'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers (reset arrives through clr_i)
  always_ff @(posedge clk) begin
    bit_cnt_q  <= bit_cnt_d;
    word_cnt_q <= word_cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/ser_deframer.sv
// ============================================================================
// Module : ser_deframer
// Brief  : Serial frame-sync deframer: hunts SYNC_WORD, confirms LOCK_CNT
//          correctly spaced syncs, emits FRAME_LEN words per frame while
//          locked and drops lock after MISS_MAX consecutive missed syncs.
// Config : SER_DEFRAMER_PARITY_EN - data slots carry a trailing even-parity
//          bit and parity_err is reported with each word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_deframer
  import ser_deframer_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int         FRAME_LEN = 4,
  parameter int         LOCK_CNT  = 2,
  parameter int         MISS_MAX  = 2
) (
  input  wire logic      clk,
  input  wire logic      reset,
  ser_deframer_if.slave  ser_if
);

`ifdef SER_DEFRAMER_PARITY_EN
  localparam int DATA_SLOT_LEN = DATA_SLOT_LEN_PAR;
  localparam int BIT_W         = BIT_CNT_W_PAR;
  localparam int SR_W          = 8;  // holds the full data byte at the parity bit
`else
  localparam int DATA_SLOT_LEN = DATA_SLOT_LEN_NOPAR;
  localparam int BIT_W         = BIT_CNT_W_NOPAR;
  localparam int SR_W          = 7;  // the oldest bit is never observed here
`endif

  deframer_state_t   state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              locked_q, locked_d;
  logic              sync_err_q, sync_err_d;
  logic [WORD_W-1:0] cand;
  logic              sync_hit;
  logic              cnt_clr;
  logic              cnt_adv;
  logic              slot_done;
  logic              sync_slot;
`ifdef SER_DEFRAMER_PARITY_EN
  logic              parity_err_q, parity_err_d;
  assign cand = {sr_q[6:0], ser_if.ser_in};
`else
  assign cand = {sr_q, ser_if.ser_in};
`endif

  assign sync_hit = (cand == SYNC_WORD);
  assign cnt_adv  = ser_if.ser_valid & (state_q != HUNT);

  deframer_slot_counter #(
    .FRAME_LEN     (FRAME_LEN),
    .DATA_SLOT_LEN (DATA_SLOT_LEN),
    .BIT_W         (BIT_W)
  ) u_slot_cnt (
    .clk         (clk),
    .clr_i       (cnt_clr),
    .adv_i       (cnt_adv),
    .slot_done_o (slot_done),
    .sync_slot_o (sync_slot)
  );

  // Next-state, counter and output decisions for each accepted bit
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    good_cnt_d   = good_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    cnt_clr      = reset;
`ifdef SER_DEFRAMER_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (ser_if.ser_valid) begin
      sr_d = cand[SR_W-1:0];
      case (state_q)
        HUNT: begin
          if (sync_hit) begin
            cnt_clr    = 1'b1;
            good_cnt_d = 4'd1;
            miss_cnt_d = 4'd0;
            state_d    = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          // Data slots are skipped; only the sync slot decides
          if (slot_done && sync_slot) begin
            if (sync_hit) begin
              good_cnt_d = sat_inc4(good_cnt_q);
              if (good_cnt_d >= 4'(LOCK_CNT)) begin
                state_d = LOCKED;
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          if (slot_done) begin
            if (sync_slot) begin
              // A missed sync keeps slot timing; it is never emitted as data
              if (sync_hit) begin
                miss_cnt_d = 4'd0;
              end else begin
                sync_err_d = 1'b1;
                miss_cnt_d = sat_inc4(miss_cnt_q);
                if (miss_cnt_d >= 4'(MISS_MAX)) begin
                  state_d = HUNT;
                end
              end
            end else begin
              dout_valid_d = 1'b1;
`ifdef SER_DEFRAMER_PARITY_EN
              dout_d       = sr_q;
              parity_err_d = ^{sr_q, ser_if.ser_in};
`else
              dout_d       = cand;
`endif
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State and output registers; reset wins over a simultaneous accepted bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      good_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef SER_DEFRAMER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      good_cnt_q   <= good_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
`ifdef SER_DEFRAMER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign ser_if.dout       = dout_q;
  assign ser_if.dout_valid = dout_valid_q;
  assign ser_if.locked     = locked_q;
  assign ser_if.sync_err   = sync_err_q;
`ifdef SER_DEFRAMER_PARITY_EN
  assign ser_if.parity_err = parity_err_q;
`else
  assign ser_if.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ser_deframer.sv
// ============================================================================
// Module : tb_ser_deframer
// Brief  : Self-checking bench for ser_deframer. A slot-level reference
//          model predicts every cycle's outputs; a vector table adds
//          end-of-stream expectations for the main scenarios.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_deframer;
  import ser_deframer_pkg::*;

  localparam logic [7:0] SW = 8'hA5;
  localparam int FL = 4;
  localparam int LC = 2;
  localparam int MM = 2;
`ifdef SER_DEFRAMER_PARITY_EN
  localparam int DSLOT = 9;
`else
  localparam int DSLOT = 8;
`endif
  localparam int PAR  = (DSLOT == 9) ? 1 : 0;
  localparam int MAXB = 1024;

  typedef struct {
    logic [7:0]  pre;
    int          pre_len;
    int          nfr;
    logic [39:0] s;      // sync byte per frame, first frame in the top byte
    logic [31:0] w;      // the four data words, first in the top byte
    logic [3:0]  pflip;  // bad parity on word j of the last frame
    int          gap;    // 0 none, 1 alternate, 2 random idles
    int          e_ndv;
    logic [7:0]  e_last;
    int          e_lock;
    int          e_nse;
    int          e_npe;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ser_deframer_if bus ();

  ser_deframer #(
    .SYNC_WORD (SW),
    .FRAME_LEN (FL),
    .LOCK_CNT  (LC),
    .MISS_MAX  (MM)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_if (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cnt_dv, cnt_se, cnt_pe;
  logic [7:0] last_dout;

  bit         bits [$];
  logic [7:0] e_dout [MAXB];
  bit         e_dv [MAXB];
  bit         e_lk [MAXB];
  bit         e_se [MAXB];
  bit         e_pe [MAXB];

  function automatic logic [11:0] obs();
    return {bus.dout, bus.dout_valid, bus.locked, bus.sync_err, bus.parity_err};
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {dout,dv,lk,se,pe}=%h_%b want %h_%b", nm, act[11:4], act[3:0], exp[11:4], exp[3:0]);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Last 8 accepted bits ending at index j (bits before the stream are 0)
  function automatic logic [7:0] window(input int j);
    logic [7:0] v = 8'h00;
    for (int k = 0; k < 8; k++) begin
      int idx = j - 7 + k;
      v = {v[6:0], (idx >= 0) ? bits[idx] : 1'b0};
    end
    return v;
  endfunction

  // Walk the stream slot by slot and record the outputs after each bit
  task automatic build_model();
    int n, p, good, miss, slot, len, last;
    bit hunting, lk, ok;
    logic [7:0] dcur, w;
    n = bits.size(); p = 0; good = 0; miss = 0; slot = 0;
    hunting = 1'b1; lk = 1'b0; dcur = 8'h00;
    for (int k = 0; k < n; k++) begin
      e_dv[k] = 1'b0; e_se[k] = 1'b0; e_pe[k] = 1'b0;
    end
    while (p < n) begin
      if (hunting) begin
        if (window(p) == SW) begin
          hunting = 1'b0; good = 1; miss = 0; slot = 0;
          if (LC == 1) lk = 1'b1;
        end
        e_lk[p] = lk; e_dout[p] = dcur; p++;
      end else begin
        len  = (slot == FL) ? 8 : DSLOT;
        last = p + len - 1;
        for (int k = p; k < last && k < n; k++) begin
          e_lk[k] = lk; e_dout[k] = dcur;
        end
        if (last >= n) begin
          p = n;
        end else begin
          if (slot < FL) begin
            if (lk) begin
              w = 8'h00;
              for (int k = 0; k < 8; k++) w = {w[6:0], bits[p + k]};
              dcur = w; e_dv[last] = 1'b1;
              if (DSLOT == 9) e_pe[last] = (^w) ^ bits[p + 8];
            end
            slot++;
          end else begin
            slot = 0;
            ok = (window(last) == SW);
            if (!lk) begin
              if (ok) begin
                good = (good < 15) ? good + 1 : 15;
                if (good >= LC) lk = 1'b1;
              end else begin
                hunting = 1'b1;
              end
            end else if (ok) begin
              miss = 0;
            end else begin
              e_se[last] = 1'b1;
              miss = (miss < 15) ? miss + 1 : 15;
              if (miss >= MM) begin
                lk = 1'b0; hunting = 1'b1;
              end
            end
          end
          e_lk[last] = lk; e_dout[last] = dcur; p = last + 1;
        end
      end
    end
  endtask

  task automatic tally();
    if (bus.dout_valid) begin cnt_dv++; last_dout = bus.dout; end
    if (bus.sync_err) cnt_se++;
    if (bus.parity_err) cnt_pe++;
  endtask

  // Reset for two cycles (ser_valid high), then play the stream with idles
  task automatic run_seg(input string nm, input int gap);
    int n, idle;
    logic [11:0] prev;
    build_model();
    n = bits.size();
    cnt_dv = 0; cnt_se = 0; cnt_pe = 0; last_dout = 8'h00;
    reset = 1'b1; bus.ser_valid = 1'b1;
    repeat (2) begin
      bus.ser_in = 1'($urandom);
      @(posedge clk); #1;
      chk({nm, "/reset"}, obs(), 12'h000);
    end
    reset = 1'b0;
    prev = 12'h000;
    for (int i = 0; i < n; i++) begin
      idle = (gap == 0) ? 0 : (gap == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) begin
        bus.ser_valid = 1'b0; bus.ser_in = 1'($urandom);
        @(posedge clk); #1;
        chk($sformatf("%s/idle%0d", nm, i), obs(), {prev[11:4], 1'b0, prev[2], 2'b00});
        tally();
      end
      bus.ser_valid = 1'b1; bus.ser_in = bits[i];
      @(posedge clk); #1;
      prev = {e_dout[i], e_dv[i], e_lk[i], e_se[i], e_pe[i]};
      chk($sformatf("%s/bit%0d", nm, i), obs(), prev);
      tally();
    end
    bus.ser_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
  endtask

  task automatic push_data(input logic [7:0] w, input bit flip);
    push_byte(w);
    if (DSLOT == 9) bits.push_back((^w) ^ flip);
  endtask

  task automatic build_vec(input vec_t v);
    bits.delete();
    for (int k = v.pre_len - 1; k >= 0; k--) bits.push_back(v.pre[k]);
    for (int f = 0; f < v.nfr; f++) begin
      push_byte(v.s[39 - 8*f -: 8]);
      for (int j = 0; j < 4; j++)
        push_data(v.w[31 - 8*j -: 8], (f == v.nfr - 1) ? v.pflip[j] : 1'b0);
    end
  endtask

  function automatic vec_t mk(logic [7:0] pre, int pl, int nfr, logic [39:0] s,
                              logic [31:0] w, logic [3:0] pf, int gap, int ndv,
                              logic [7:0] last, int lk, int nse, int npe);
    vec_t v;
    v.pre = pre; v.pre_len = pl; v.nfr = nfr; v.s = s; v.w = w; v.pflip = pf;
    v.gap = gap; v.e_ndv = ndv; v.e_last = last; v.e_lock = lk; v.e_nse = nse;
    v.e_npe = npe;
    return v;
  endfunction

  initial begin
    vec_t tbl [8];
    logic [7:0] b22;
    int pl, nf;

    tbl[0] = mk(8'h05, 3, 3, 40'hA5A5A5_0000, 32'h11223344, 4'h0, 0, 8, 8'h44, 1, 0, 0);
    tbl[1] = mk(8'h05, 3, 3, 40'hA5A5A5_0000, 32'h11223344, 4'h0, 1, 8, 8'h44, 1, 0, 0);
    tbl[2] = mk(8'h05, 3, 3, 40'hA5A55A_0000, 32'h11223344, 4'h0, 0, 8, 8'h44, 1, 1, 0);
    tbl[3] = mk(8'h05, 3, 3, 40'hA55AA5_0000, 32'h11223344, 4'h0, 0, 0, 8'h00, 0, 0, 0);
    tbl[4] = mk(8'h05, 3, 5, 40'hA5A55A5AA5,  32'h11223344, 4'h0, 0, 8, 8'h44, 0, 2, 0);
    tbl[5] = mk(8'h05, 3, 3, 40'hA5A5A5_0000, 32'h11223344, 4'h1, 0, 8, 8'h44, 1, 0, PAR);
    tbl[6] = mk(8'h00, 0, 4, 40'hA5A5A5A5_00, 32'h3CC3FF00, 4'h0, 0, 12, 8'h00, 1, 0, 0);
    tbl[7] = mk(8'h05, 3, 3, 40'hA5A5A5_0000, 32'h11223344, 4'h0, 2, 8, 8'h44, 1, 0, 0);

    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 8; t++) begin
      build_vec(tbl[t]);
      run_seg($sformatf("vec%0d", t), tbl[t].gap);
      chk_int($sformatf("vec%0d/ndv", t), cnt_dv, tbl[t].e_ndv);
      chk_int($sformatf("vec%0d/last", t), int'(last_dout), int'(tbl[t].e_last));
      chk_int($sformatf("vec%0d/lock", t), int'(bus.locked), tbl[t].e_lock);
      chk_int($sformatf("vec%0d/nse", t), cnt_se, tbl[t].e_nse);
      chk_int($sformatf("vec%0d/npe", t), cnt_pe, tbl[t].e_npe);
    end

    // Reset arrives four bits into data word 22 of the first locked frame
    b22 = 8'h22;
    bits.delete();
    bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1);
    push_byte(SW);
    push_data(8'h11, 1'b0); push_data(8'h22, 1'b0); push_data(8'h33, 1'b0); push_data(8'h44, 1'b0);
    push_byte(SW);
    push_data(8'h11, 1'b0);
    for (int k = 7; k >= 4; k--) bits.push_back(b22[k]);
    run_seg("rstA", 0);
    chk_int("rstA/ndv", cnt_dv, 1);
    chk_int("rstA/lock", int'(bus.locked), 1);

    bits.delete();
    for (int k = 3; k >= 0; k--) bits.push_back(b22[k]);
    if (DSLOT == 9) bits.push_back(^b22);
    push_data(8'h33, 1'b0); push_data(8'h44, 1'b0);
    for (int f = 0; f < 2; f++) begin
      push_byte(SW);
      push_data(8'h11, 1'b0); push_data(8'h22, 1'b0); push_data(8'h33, 1'b0); push_data(8'h44, 1'b0);
    end
    run_seg("rstB", 0);
    chk_int("rstB/ndv", cnt_dv, 4);
    chk_int("rstB/lock", int'(bus.locked), 1);

    // Random streams: occasional corrupted syncs, bad parity and idle gaps
    for (int r = 0; r < 12; r++) begin
      bits.delete();
      pl = int'($urandom_range(0, 12));
      for (int k = 0; k < pl; k++) bits.push_back(1'($urandom));
      nf = int'($urandom_range(3, 6));
      for (int f = 0; f < nf; f++) begin
        push_byte(($urandom_range(0, 4) == 0) ? 8'($urandom) : SW);
        for (int j = 0; j < 4; j++) push_data(8'($urandom), ($urandom_range(0, 7) == 0));
      end
      run_seg($sformatf("rnd%0d", r), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
